miriscv_irq_ctrl: RTL

- Parametrised interrupt controller between peripheral request lines and the miriscv core trap logic.
- Latches N_IRQ requests; each channel is edge- or level-sensitive.
- Masks requests with the core's MIE vector, arbitrates by fixed priority or round-robin, and hands one cause at a time to the core through an ack/return handshake.
- Pulses a one-hot int_fin_o when the handler returns (mret).

---
 rtl/miriscv_irq_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/miriscv_irq_ctrl.sv
// miriscv_irq_ctrl: latches peripheral interrupt requests (edge or level per
// channel), masks them with the core's MIE vector, arbitrates by fixed priority
// or round-robin and hands one cause at a time to the core. The core takes the
// cause with irq_ack_i and returns with irq_ret_i. A one-hot int_fin_o pulse
// then marks completion.
module miriscv_irq_ctrl #(
  parameter int          N_IRQ     = 32,
  parameter int          CAUSE_W   = $clog2(N_IRQ),
  parameter logic [31:0] EDGE_MASK = 32'hFFFF_FFFF,
  parameter int          ARB_MODE  = 0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [N_IRQ-1:0]   int_req_i,
  input  logic [N_IRQ-1:0]   mie_i,
  output logic               irq_o,
  output logic [CAUSE_W-1:0] irq_cause_o,
  input  logic               irq_ack_i,
  input  logic               irq_ret_i,
  output logic [N_IRQ-1:0]   int_fin_o,
  output logic               busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2,
    ST_FIN     = 2'd3
  } state_t;

  localparam logic [N_IRQ-1:0]   EDGE_VEC  = EDGE_MASK[N_IRQ-1:0];
  localparam logic [CAUSE_W-1:0] LAST_INIT = CAUSE_W'(N_IRQ - 1);

  state_t             state_r;
  state_t             state_s;
  logic [N_IRQ-1:0]   pending_r;
  logic [N_IRQ-1:0]   pending_s;
  logic [N_IRQ-1:0]   prev_req_r;
  logic [N_IRQ-1:0]   set_s;
  logic [N_IRQ-1:0]   clr_s;
  logic [N_IRQ-1:0]   eligible_s;
  logic [N_IRQ-1:0]   fin_s;
  logic [CAUSE_W-1:0] last_served_r;
  logic [CAUSE_W-1:0] last_served_s;
  logic [CAUSE_W-1:0] cause_s;
  logic [CAUSE_W-1:0] pick_s;
  logic               pick_valid_s;

  // One-hot decode of a channel index.
  function automatic logic [N_IRQ-1:0] one_hot(input logic [CAUSE_W-1:0] idx);
    logic [N_IRQ-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

  // Pending capture and clear; edge channels let a same-cycle new edge beat
  // the FIN clear, level channels let the clear win and re-pend next cycle.
  always_comb begin
    set_s = int_req_i & ~(prev_req_r & EDGE_VEC);
    if (state_r == ST_FIN) begin
      clr_s = one_hot(irq_cause_o);
    end else begin
      clr_s = '0;
    end
    pending_s  = (pending_r & ~clr_s) | (set_s & ~(clr_s & ~EDGE_VEC));
    eligible_s = pending_r & mie_i;
  end

  // Arbitration over the eligible vector: lowest index, or first index after
  // the last served channel with wrap-around.
  always_comb begin
    int idx;
    idx          = 32'sd0;
    pick_s       = '0;
    pick_valid_s = 1'b0;
    for (int i = 0; i < N_IRQ; i++) begin
      if (ARB_MODE == 32'sd1) begin
        idx = (int'(last_served_r) + 32'sd1 + i) % N_IRQ;
      end else begin
        idx = i;
      end
      if (!pick_valid_s && eligible_s[CAUSE_W'(idx)]) begin
        pick_s       = CAUSE_W'(idx);
        pick_valid_s = 1'b1;
      end else begin
        pick_valid_s = pick_valid_s;
      end
    end
  end

  // Next-state logic for the request/service handshake.
  always_comb begin
    state_s       = state_r;
    cause_s       = irq_cause_o;
    last_served_s = last_served_r;
    fin_s         = '0;
    case (state_r)
      ST_IDLE: begin
        if (pick_valid_s) begin
          state_s       = ST_REQ;
          cause_s       = pick_s;
          last_served_s = pick_s;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (irq_ack_i) begin
          state_s = ST_SERVICE;
        end else begin
          state_s = ST_REQ;
        end
      end
      ST_SERVICE: begin
        if (irq_ret_i) begin
          state_s = ST_FIN;
          fin_s   = one_hot(irq_cause_o);
        end else begin
          state_s = ST_SERVICE;
        end
      end
      ST_FIN: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, pending bookkeeping and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r       <= ST_IDLE;
      pending_r     <= '0;
      prev_req_r    <= '0;
      last_served_r <= LAST_INIT;
      irq_o         <= 1'b0;
      irq_cause_o   <= '0;
      int_fin_o     <= '0;
      busy_o        <= 1'b0;
    end else begin
      state_r       <= state_s;
      pending_r     <= pending_s;
      prev_req_r    <= int_req_i;
      last_served_r <= last_served_s;
      irq_o         <= (state_s == ST_REQ);
      irq_cause_o   <= cause_s;
      int_fin_o     <= fin_s;
      busy_o        <= (state_s != ST_IDLE);
    end
  end

endmodule
